// File: rtl/master_port.sv
// Serial system bus master port: takes one parallel request, arbitrates for the bus,
// shifts address then write data out LSB first, and deserialises read data back.
// Optional read-wait timeout is enabled by defining MASTER_TIMEOUT_EN.
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  drvalid,
    output logic                  derror,
    output logic                  mbreq,
    input  logic                  mbgrant,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  srdata,
    input  logic                  svalid,
    input  logic                  sready,
    input  logic                  ssplit
);
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam int TXW  = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, REQ, WAITS, ADDR, WDATA, RWAIT, RDATA} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TXW-1:0]        tx_q, tx_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
    logic                  drvalid_q, drvalid_d;
    logic                  derror_q, derror_d;
    logic                  dready_q, dready_d;
    logic                  mbreq_q, mbreq_d;
    logic                  mwdata_q, mwdata_d;
    logic                  mmode_q, mmode_d;
    logic                  mvalid_q, mvalid_d;

`ifdef MASTER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wcnt_q, wcnt_d;
`else
    localparam int unused_timeout = TIMEOUT;
    logic unused_split;
    assign unused_split = ssplit;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        mode_d    = mode_q;
        rx_d      = rx_q;
        drdata_d  = drdata_q;
        drvalid_d = 1'b0;
        derror_d  = 1'b0;
        mwdata_d  = 1'b0;
`ifdef MASTER_TIMEOUT_EN
        wcnt_d    = wcnt_q;
`endif
        case (state_q)
            IDLE: if (dvalid) begin
                mode_d  = dmode;
                tx_d    = {dwdata, daddr};
                state_d = REQ;
            end
            REQ:   if (mbgrant) state_d = WAITS;
            WAITS: if (sready)  state_d = ADDR;
            ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    cnt_d   = '0;
                    state_d = mode_q ? WDATA : RWAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WDATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RWAIT, RDATA: begin
                if (svalid) begin
                    rx_d = {srdata, rx_q[DATA_WIDTH-1:1]};
`ifdef MASTER_TIMEOUT_EN
                    wcnt_d = '0;
`endif
                    if (cnt_q == DATA_LAST) begin
                        cnt_d     = '0;
                        drdata_d  = rx_d;
                        drvalid_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = RDATA;
                    end
                end
`ifdef MASTER_TIMEOUT_EN
                else if (!ssplit) begin
                    if (wcnt_q == WW'(TIMEOUT - 1)) begin
                        wcnt_d   = '0;
                        cnt_d    = '0;
                        derror_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // The serial bit for the coming cycle is the head of the shift register.
        if (state_d == ADDR || state_d == WDATA) begin
            mwdata_d = tx_q[0];
            tx_d     = tx_q >> 1;
        end
        mvalid_d = (state_d == ADDR) || (state_d == WDATA);
        mmode_d  = mvalid_d & mode_q;
        mbreq_d  = (state_d != IDLE);
        dready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_q      <= '0;
            mode_q    <= 1'b0;
            rx_q      <= '0;
            drdata_q  <= '0;
            drvalid_q <= 1'b0;
            derror_q  <= 1'b0;
            dready_q  <= 1'b1;
            mbreq_q   <= 1'b0;
            mwdata_q  <= 1'b0;
            mmode_q   <= 1'b0;
            mvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            mode_q    <= mode_d;
            rx_q      <= rx_d;
            drdata_q  <= drdata_d;
            drvalid_q <= drvalid_d;
            derror_q  <= derror_d;
            dready_q  <= dready_d;
            mbreq_q   <= mbreq_d;
            mwdata_q  <= mwdata_d;
            mmode_q   <= mmode_d;
            mvalid_q  <= mvalid_d;
        end
    end

`ifdef MASTER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rstn) wcnt_q <= '0;
        else       wcnt_q <= wcnt_d;
    end
`endif

    assign dready  = dready_q;
    assign drdata  = drdata_q;
    assign drvalid = drvalid_q;
    assign derror  = derror_q;
    assign mbreq   = mbreq_q;
    assign mwdata  = mwdata_q;
    assign mmode   = mmode_q;
    assign mvalid  = mvalid_q;
endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: serial bits and read words are predicted into
// queues at request time and checked by monitors as the port produces them.
module tb_master_port;
    localparam int AW = 12;
    localparam int DW = 8;
`ifdef MASTER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 64;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          dvalid = 1'b0, dmode = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dwdata = '0;
    logic          dready, drvalid, derror, mbreq, mwdata, mmode, mvalid;
    logic [DW-1:0] drdata;
    logic          mbgrant = 1'b1, srdata = 1'b0, svalid = 1'b0, sready = 1'b1, ssplit = 1'b0;

    int total = 0;
    int bad = 0;
    int drv_cnt = 0;
    bit mon_en = 1'b1;
    logic [1:0]    exp_q[$];   // {mode, bit}
    logic [DW-1:0] rd_q[$];

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .dvalid(dvalid), .dmode(dmode), .daddr(daddr),
        .dwdata(dwdata), .dready(dready), .drdata(drdata), .drvalid(drvalid),
        .derror(derror), .mbreq(mbreq), .mbgrant(mbgrant), .mwdata(mwdata),
        .mmode(mmode), .mvalid(mvalid), .srdata(srdata), .svalid(svalid),
        .sready(sready), .ssplit(ssplit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Serial output scoreboard
    always @(negedge clk) begin
        if (mon_en && mvalid) begin
            if (exp_q.size() == 0) begin
                check("mvalid_unexpected", 32'(mvalid), 32'd0);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                check("mwdata", 32'(mwdata), 32'(e[0]));
                check("mmode", 32'(mmode), 32'(e[1]));
            end
        end
    end

    // Read result scoreboard
    always @(negedge clk) begin
        if (drvalid) begin
            drv_cnt++;
            if (rd_q.size() == 0) begin
                check("drvalid_unexpected", 32'(drvalid), 32'd0);
            end else begin
                logic [DW-1:0] e;
                e = rd_q.pop_front();
                check("drdata", 32'(drdata), 32'(e));
            end
        end
    end

    task automatic wait_idle(input string tag);
        int t = 0;
        while (!dready && t < 300) begin tick(); t++; end
        check({tag, "_idle_timeout"}, 32'(t < 300), 32'd1);
    endtask

    task automatic issue(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_idle("issue");
        dvalid = 1'b1; dmode = m; daddr = a; dwdata = d;
        for (int i = 0; i < AW; i++) exp_q.push_back({m, a[i]});
        if (m) for (int i = 0; i < DW; i++) exp_q.push_back({m, d[i]});
        tick();
        dvalid = 1'b0;
    endtask

    // Returns the length of the next contiguous mvalid burst.
    task automatic burst(input string tag, output int len);
        int t = 0;
        while (!mvalid && t < 200) begin tick(); t++; end
        check({tag, "_start_timeout"}, 32'(t < 200), 32'd1);
        len = 0;
        while (mvalid && len < 100) begin len++; tick(); end
    endtask

    task automatic send_read(input logic [DW-1:0] d, input int gap_after);
        for (int i = 0; i < DW; i++) begin
            svalid = 1'b1; srdata = d[i];
            tick();
            if (i == gap_after) begin
                svalid = 1'b0; srdata = 1'b1;
                tick(); tick();
            end
        end
        svalid = 1'b0; srdata = 1'b0;
    endtask

    initial begin
        int len, n, cnt0;
        tick(); tick();
        check("rst_dready", 32'(dready), 32'd1);
        check("rst_mbreq", 32'(mbreq), 32'd0);
        check("rst_mvalid", 32'(mvalid), 32'd0);
        check("rst_drvalid", 32'(drvalid), 32'd0);
        check("rst_derror", 32'(derror), 32'd0);
        check("rst_drdata", 32'(drdata), 32'd0);
        check("rst_mwdata", 32'(mwdata), 32'd0);
        rstn = 1'b1;
        tick();

        // Write, immediate grant
        issue(1'b1, 12'hA5C, 8'h3C);
        check("wr_mbreq", 32'(mbreq), 32'd1);
        check("wr_dready_busy", 32'(dready), 32'd0);
        burst("wr", len);
        check("wr_len", 32'(len), 32'(AW + DW));
        check("wr_dready_back", 32'(dready), 32'd1);
        check("wr_mbreq_drop", 32'(mbreq), 32'd0);

        // Read of 0x96
        cnt0 = drv_cnt;
        rd_q.push_back(8'h96);
        issue(1'b0, 12'h123, 8'hFF);
        burst("rd", len);
        check("rd_len", 32'(len), 32'(AW));
        send_read(8'h96, -1);
        wait_idle("rd");
        tick(); tick();
        check("rd_pulses", 32'(drv_cnt - cnt0), 32'd1);
        check("rd_hold", 32'(drdata), 32'h96);

        // Delayed grant, then slave busy
        mbgrant = 1'b0; sready = 1'b0;
        issue(1'b1, 12'h5A3, 8'hC1);
        for (int i = 0; i < 5; i++) begin
            check("dly_mbreq_grant", 32'(mbreq), 32'd1);
            check("dly_mvalid_grant", 32'(mvalid), 32'd0);
            tick();
        end
        mbgrant = 1'b1;
        tick();
        mbgrant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("dly_mbreq_sready", 32'(mbreq), 32'd1);
            check("dly_mvalid_sready", 32'(mvalid), 32'd0);
            tick();
        end
        sready = 1'b1;
        burst("dly", len);
        check("dly_len", 32'(len), 32'(AW + DW));
        wait_idle("dly");
        mbgrant = 1'b1;

        // Read with a two-cycle svalid gap
        cnt0 = drv_cnt;
        rd_q.push_back(8'h81);
        issue(1'b0, 12'hFFF, 8'h00);
        burst("gap", len);
        check("gap_len", 32'(len), 32'(AW));
        send_read(8'h81, 3);
        wait_idle("gap");
        tick();
        check("gap_pulses", 32'(drv_cnt - cnt0), 32'd1);
        check("gap_hold", 32'(drdata), 32'h81);

`ifdef MASTER_TIMEOUT_EN
        cnt0 = drv_cnt;
        issue(1'b0, 12'h0F0, 8'h00);
        burst("to", len);
        n = 0;
        while (!derror && n < 100) begin tick(); n++; end
        check("to_latency", 32'(n), 32'(TO));
        tick();
        check("to_derror_pulse", 32'(derror), 32'd0);
        check("to_dready", 32'(dready), 32'd1);
        check("to_drdata", 32'(drdata), 32'h81);

        issue(1'b0, 12'h00F, 8'h00);
        burst("tosp", len);
        ssplit = 1'b1;
        n = 0;
        while (!derror && n < 100) begin
            tick(); n++;
            if (n == 10) ssplit = 1'b0;
        end
        ssplit = 1'b0;
        check("tosp_latency", 32'(n), 32'(TO + 10));
        tick();
        check("to_no_drvalid", 32'(drv_cnt - cnt0), 32'd0);
`endif

        // Reset during the 6th address bit
        mon_en = 1'b0;
        issue(1'b1, 12'h7E1, 8'h55);
        n = 0; cnt0 = 0;
        while (cnt0 < 6 && n < 200) begin
            tick(); n++;
            if (mvalid) cnt0++;
        end
        check("rst6_reached", 32'(cnt0), 32'd6);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rst6_mvalid", 32'(mvalid), 32'd0);
        check("rst6_mbreq", 32'(mbreq), 32'd0);
        check("rst6_dready", 32'(dready), 32'd1);
        exp_q.delete();
        tick();
        mon_en = 1'b1;
        issue(1'b1, 12'h3A6, 8'hE7);
        burst("post", len);
        check("post_len", 32'(len), 32'(AW + DW));
        wait_idle("post");
        tick();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
